// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types and constants
package calc_pkg;

    // Default operand width shared by the adder, subtractor and other calculator units
    localparam int CALC_WIDTH = 8;

    // Serial adder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit combinational full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // One bit of sum and carry from two operand bits and a carry-in
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial two's-complement adder with valid/ready handshakes
module serial_adder
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_IN_BIT = CNT_W'(WIDTH - 2);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic              c_msb_q, c_msb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;

    logic              fa_s;
    logic              fa_co;

    // The single adder cell is reused every SHIFT cycle on the operand LSBs
    full_adder_cell u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, shift WIDTH bits, hold result until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: operand latch, serial add step, result capture
    always_comb begin
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        c_msb_d     = c_msb_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_co;
                cnt_d    = cnt_q + CNT_W'(1);
                // Carry produced by bit WIDTH-2 is the carry into the sign bit
                if (cnt_q == MSB_IN_BIT) begin
                    c_msb_d = fa_co;
                end
                // Final bit: the complete sum is the shift register plus this bit
                if (cnt_q == LAST_BIT) begin
                    sum_d       = {fa_s, sum_sh_q[WIDTH-1:1]};
                    carry_out_d = fa_co;
                    overflow_d  = c_msb_q ^ fa_co;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; result registers hold until the next completed add
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            c_msb_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            c_msb_q     <= c_msb_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Result outputs come straight from flops
    always_comb begin
        sum       = sum_q;
        carry_out = carry_out_q;
        overflow  = overflow_q;
    end

endmodule
